// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, legality check and sequencer states shared by the ALU control path
package alu_pkg;
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADDSUB = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_e;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADDSUB, ALU_SLT, ALU_XOR};
  endfunction
endpackage

// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if: start/done request bus between the control unit and the serial ALU sequencer
interface alu_serial_ctrl_if #(parameter int WIDTH = 8) ();
  logic             start_i;
  logic [3:0]       op_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;
  modport master (output start_i, op_i, sub_i, a_i, b_i,
                  input  busy_o, done_o, err_o, result_o, carry_o, overflow_o, zero_o);
  modport slave  (input  start_i, op_i, sub_i, a_i, b_i,
                  output busy_o, done_o, err_o, result_o, carry_o, overflow_o, zero_o);
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: drives one external 1-bit ALU slice LSB first to compute a WIDTH-bit operation
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  alu_serial_ctrl_if.slave ctrl,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_c_o,
  output logic             slice_invert_o,
  output logic             slice_less_o,
  output logic [3:0]       slice_op_o,
  input  logic             slice_res_i,
  input  logic             slice_c_i,
  input  logic             slice_set_i
);
  localparam int KW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, result_q;
  logic [3:0]       op_q;
  logic             sub_q, carry_q, msb_cin_q, cout_q, set_q;
  logic             flag_c_q, flag_v_q, zero_q, err_q;
  logic [KW-1:0]    k_q;
  logic             accept, run, last, is_slt, slt_bit;
  assign accept  = state_q == IDLE && ctrl.start_i && is_legal_op(ctrl.op_i);
  assign run     = state_q == RUN;
  assign last    = k_q == KW'(WIDTH - 1);
  assign is_slt  = op_q == ALU_SLT;
  assign slt_bit = set_q ^ msb_cin_q ^ cout_q;
  // Slice is only driven while stepping through bits; SLT runs the slice as a subtractor
  assign slice_a_o      = run & a_q[k_q];
  assign slice_b_o      = run & b_q[k_q];
  assign slice_c_o      = run & carry_q;
  assign slice_invert_o = run & (is_slt | sub_q);
  assign slice_less_o   = 1'b0;
  assign slice_op_o     = run ? (is_slt ? ALU_ADDSUB : op_q) : 4'b0000;
  assign ctrl.busy_o     = state_q != IDLE;
  assign ctrl.done_o     = state_q == DONE;
  assign ctrl.err_o      = err_q;
  assign ctrl.result_o   = result_q;
  assign ctrl.carry_o    = flag_c_q;
  assign ctrl.overflow_o = flag_v_q;
  assign ctrl.zero_o     = zero_q;
  // Next state and the partial result with the current slice bit merged in
  always_comb begin
    state_d = state_q == IDLE    ? (accept ? RUN : IDLE) :
              state_q == RUN     ? (last ? (is_slt ? SLT_FIX : DONE) : RUN) :
              state_q == SLT_FIX ? DONE : IDLE;
    res_d = res_q;
    res_d[k_q] = slice_res_i;
  end
  // Sequencer registers: capture at accept, chain carry per bit, publish flags on entry to DONE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      sub_q     <= 1'b0;
      k_q       <= '0;
      carry_q   <= 1'b0;
      res_q     <= '0;
      msb_cin_q <= 1'b0;
      cout_q    <= 1'b0;
      set_q     <= 1'b0;
      result_q  <= '0;
      flag_c_q  <= 1'b0;
      flag_v_q  <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= state_q == IDLE && ctrl.start_i && !is_legal_op(ctrl.op_i);
      if (accept) begin
        a_q     <= ctrl.a_i;
        b_q     <= ctrl.b_i;
        op_q    <= ctrl.op_i;
        sub_q   <= ctrl.sub_i;
        k_q     <= '0;
        carry_q <= ctrl.op_i == ALU_SLT || (ctrl.op_i == ALU_ADDSUB && ctrl.sub_i);
      end
      if (run) begin
        res_q   <= res_d;
        carry_q <= slice_c_i;
        k_q     <= k_q + 1'b1;
        if (last) begin
          msb_cin_q <= carry_q;
          cout_q    <= slice_c_i;
          set_q     <= slice_set_i;
          if (!is_slt) begin
            result_q <= res_d;
            zero_q   <= res_d == '0;
            flag_c_q <= op_q == ALU_ADDSUB && slice_c_i;
            flag_v_q <= op_q == ALU_ADDSUB && (carry_q ^ slice_c_i);
          end
        end
      end
      if (state_q == SLT_FIX) begin
        res_q    <= WIDTH'(slt_bit);
        result_q <= WIDTH'(slt_bit);
        zero_q   <= !slt_bit;
        flag_c_q <= cout_q;
        flag_v_q <= msb_cin_q ^ cout_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed checks of the serial ALU sequencer driving a behavioural 1-bit slice
module tb_alu_serial_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  logic s_a, s_b, s_c, s_inv, s_less, s_res, s_cout, s_set, bb;
  logic [3:0] s_op;
  alu_serial_ctrl_if #(.WIDTH(8)) bus ();
  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ctrl(bus),
    .slice_a_o(s_a), .slice_b_o(s_b), .slice_c_o(s_c), .slice_invert_o(s_inv),
    .slice_less_o(s_less), .slice_op_o(s_op),
    .slice_res_i(s_res), .slice_c_i(s_cout), .slice_set_i(s_set)
  );
  always #5 clk = ~clk;
  assign bb     = s_b ^ s_inv;
  assign s_set  = s_a ^ bb ^ s_c;
  assign s_cout = (s_a & bb) | (s_a & s_c) | (bb & s_c);
  assign s_res  = s_op == 4'b0000 ? s_a & bb :
                  s_op == 4'b0001 ? s_a | bb :
                  s_op == 4'b0010 ? s_set :
                  s_op == 4'b0011 ? s_less :
                  s_op == 4'b0100 ? s_a ^ bb : 1'b0;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [3:0] op, input logic sub, input logic [7:0] a, input logic [7:0] b,
                       output int n, output logic c0, output logic slt_drv);
    bus.op_i = op; bus.sub_i = sub; bus.a_i = a; bus.b_i = b; bus.start_i = 1;
    cyc();
    bus.start_i = 0; bus.a_i = ~a; bus.b_i = ~b; bus.sub_i = ~sub; bus.op_i = 4'b0001;
    n = 1; c0 = s_c; slt_drv = 1;
    while (!bus.done_o && n < 30) begin
      if (n <= 8) slt_drv &= (s_op == 4'b0010 && s_inv);
      cyc();
      n++;
    end
  endtask
  int n;
  logic c0, drv;
  initial begin
    bus.start_i = 0; bus.op_i = 0; bus.sub_i = 0; bus.a_i = 0; bus.b_i = 0;
    cyc(); cyc();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_zero", bus.zero_o, 0);
    chk("rst_slice", {s_a, s_b, s_c, s_inv, s_less, s_op}, 0);
    rst_n = 1;
    cyc();
    do_op(4'b0010, 0, 8'h7F, 8'h01, n, c0, drv);
    chk("add_lat", n, 9);
    chk("add_busy", bus.busy_o, 1);
    chk("add_res", bus.result_o, 8'h80);
    chk("add_flags", {bus.carry_o, bus.overflow_o, bus.zero_o}, 3'b010);
    cyc();
    chk("add_done_pulse", {bus.done_o, bus.busy_o}, 2'b00);
    chk("add_hold", bus.result_o, 8'h80);
    do_op(4'b0010, 1, 8'h05, 8'h05, n, c0, drv);
    chk("sub_cin", c0, 1);
    chk("sub_res", bus.result_o, 8'h00);
    chk("sub_flags", {bus.carry_o, bus.overflow_o, bus.zero_o}, 3'b101);
    cyc();
    do_op(4'b0011, 0, 8'h80, 8'h01, n, c0, drv);
    chk("slt1_lat", n, 10);
    chk("slt1_drive", drv, 1);
    chk("slt1_res", bus.result_o, 8'h01);
    chk("slt1_flags", {bus.carry_o, bus.overflow_o, bus.zero_o}, 3'b110);
    cyc();
    do_op(4'b0011, 0, 8'h01, 8'h80, n, c0, drv);
    chk("slt2_lat", n, 10);
    chk("slt2_res", bus.result_o, 8'h00);
    chk("slt2_flags", {bus.carry_o, bus.overflow_o, bus.zero_o}, 3'b011);
    cyc();
    do_op(4'b0000, 0, 8'hF0, 8'h3C, n, c0, drv);
    chk("and_lat", n, 9);
    chk("and_res", bus.result_o, 8'h30);
    chk("and_cv", {bus.carry_o, bus.overflow_o}, 0);
    cyc();
    do_op(4'b0001, 0, 8'hF0, 8'h3C, n, c0, drv);
    chk("or_res", bus.result_o, 8'hFC);
    chk("or_cv", {bus.carry_o, bus.overflow_o}, 0);
    cyc();
    do_op(4'b0100, 0, 8'hF0, 8'h3C, n, c0, drv);
    chk("xor_res", bus.result_o, 8'hCC);
    chk("xor_cv", {bus.carry_o, bus.overflow_o}, 0);
    cyc();
    do_op(4'b0000, 1, 8'hF0, 8'h3C, n, c0, drv);
    chk("andn_res", bus.result_o, 8'hC0);
    cyc();
    bus.op_i = 4'b0111; bus.a_i = 8'h11; bus.b_i = 8'h22; bus.start_i = 1;
    cyc();
    bus.start_i = 0;
    chk("ill_err", bus.err_o, 1);
    chk("ill_busy", bus.busy_o, 0);
    cyc();
    chk("ill_err_pulse", bus.err_o, 0);
    c0 = 0;
    for (int i = 0; i < 10; i++) begin c0 |= bus.done_o | bus.busy_o; cyc(); end
    chk("ill_no_done", c0, 0);
    chk("ill_hold", bus.result_o, 8'hC0);
    bus.op_i = 4'b0010; bus.sub_i = 0; bus.a_i = 8'h10; bus.b_i = 8'h20; bus.start_i = 1;
    cyc();
    bus.start_i = 0;
    cyc(); cyc();
    bus.a_i = 8'hFF; bus.b_i = 8'hFF; bus.start_i = 1;
    cyc();
    bus.start_i = 0;
    n = 4;
    while (!bus.done_o && n < 30) begin cyc(); n++; end
    chk("ign_lat", n, 9);
    chk("ign_res", bus.result_o, 8'h30);
    chk("ign_flags", {bus.carry_o, bus.overflow_o, bus.zero_o}, 3'b000);
    cyc();
    chk("ign_not_queued", bus.busy_o, 0);
    bus.a_i = 8'h55; bus.b_i = 8'h0A; bus.start_i = 1;
    cyc();
    bus.start_i = 0;
    cyc(); cyc(); cyc();
    rst_n = 0;
    #1;
    chk("rst_mid_out", {bus.busy_o, bus.done_o, bus.err_o, bus.result_o, bus.carry_o, bus.overflow_o, bus.zero_o}, 0);
    chk("rst_mid_slice", {s_a, s_b, s_c, s_inv, s_less, s_op}, 0);
    c0 = 0;
    for (int i = 0; i < 10; i++) begin cyc(); c0 |= bus.done_o; end
    chk("rst_mid_no_done", c0, 0);
    rst_n = 1;
    cyc();
    do_op(4'b0010, 0, 8'h03, 8'h04, n, c0, drv);
    chk("post_rst_lat", n, 9);
    chk("post_rst_res", bus.result_o, 8'h07);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
